// File: rtl/branch_resolver_pkg.sv
// ============================================================================
// Module  : branch_resolver_pkg
// Brief   : Shared LC-3 types and constants for the BR resolution slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_resolver_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [3:0] OPCODE_BR  = 4'b0000;

    localparam int         OPCODE_MSB = 15;
    localparam int         OPCODE_LSB = 12;
    localparam int         NZP_MSB    = 11;
    localparam int         NZP_LSB    = 9;
    localparam int         OFFSET_MSB = 8;
    localparam int         OFFSET_LSB = 0;

    localparam word_t      COUNT_MAX  = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/branch_target_adder.sv
// ============================================================================
// Module  : branch_target_adder
// Brief   : Combinational PC + SEXT16(offset9), wrapping modulo 2^16.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_adder
    import branch_resolver_pkg::*;
(
    input  logic [8:0] offset9,
    input  word_t      pc,
    output word_t      target
);

    word_t offset_sext;

    assign offset_sext = {{7{offset9[8]}}, offset9};
    assign target      = pc + offset_sext;

endmodule

`default_nettype wire

// File: rtl/branch_resolver.sv
// ============================================================================
// Module  : branch_resolver
// Brief   : LC-3 BR resolver: evaluates nzp against N/Z/P, computes target,
//           strobes a PC load when taken and counts taken branches.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolver
    import branch_resolver_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Bus_In,
    input  logic        Start,
    input  logic        N,
    input  logic        Z,
    input  logic        P,
    input  logic [15:0] PC,
    output logic        Busy,
    output logic        BEN,
    output logic [15:0] Target,
    output logic        Load_PC,
    output logic        Done,
    output logic [15:0] Taken_Count
);

    state_t      state;
    state_t      next_state;

    logic [3:0]  opcode;
    logic [2:0]  mask;
    logic [8:0]  offset9;
    logic        ben_next;
    word_t       target_sum;
    word_t       target_q;
    word_t       taken_count;
    logic        ben_q;

    branch_target_adder u_adder (
        .offset9 (offset9),
        .pc      (PC),
        .target  (target_sum)
    );

    assign ben_next = (opcode == OPCODE_BR) && (|(mask & {N, Z, P}));

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (Start) next_state = ST_EVAL;
            ST_EVAL:     next_state = ben_next ? ST_REDIRECT : ST_DONE;
            ST_REDIRECT: next_state = ST_DONE;
            ST_DONE:     next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state != ST_IDLE);
        Load_PC = (state == ST_REDIRECT);
        Done    = (state == ST_DONE);
    end

    // Instruction fields are latched once so Bus_In may change during EVAL.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            opcode      <= '0;
            mask        <= '0;
            offset9     <= '0;
            ben_q       <= 1'b0;
            target_q    <= '0;
            taken_count <= '0;
        end else begin
            if (state == ST_IDLE && Start) begin
                opcode  <= Bus_In[OPCODE_MSB:OPCODE_LSB];
                mask    <= Bus_In[NZP_MSB:NZP_LSB];
                offset9 <= Bus_In[OFFSET_MSB:OFFSET_LSB];
            end
            if (state == ST_EVAL) begin
                ben_q    <= ben_next;
                target_q <= target_sum;
            end
            if (state == ST_REDIRECT && taken_count != COUNT_MAX) begin
                taken_count <= taken_count + 16'd1;
            end
        end
    end

    assign BEN         = ben_q;
    assign Target      = target_q;
    assign Taken_Count = taken_count;

endmodule

`default_nettype wire
